irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 115 +++++++++++
 tb/tb_irq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes raw device requests, latches them as
// edge- or level-mode pending bits, masks them and presents the result to CP0.
module irq_ctrl #(
    parameter int unsigned N_SRC = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [2:0]       reg_addr_i,
    input  logic             reg_we_i,
    input  logic [31:0]      reg_data_i,
    output logic [31:0]      reg_data_o,
    output logic [31:0]      devices_interrupt
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MODE    = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_RAW     = 3'd3;
    localparam logic [2:0] ADDR_FORCE   = 3'd4;

    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [31:0]      rdata_d;
    logic [31:0]      irq_out_d;

    logic [N_SRC-1:0] wdata;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] force_set;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] mode_chg;

    // Write-data bits beyond the source count have no storage.
    logic unused_wdata;
    assign unused_wdata = ^reg_data_i;

    assign wdata    = reg_data_i[N_SRC-1:0];
    assign edge_det = s2_q & ~s3_q;

    // Decode register write strobes into per-bit set/clear/change vectors.
    always_comb begin
        force_set = '0;
        pend_clr  = '0;
        mode_chg  = '0;
        mode_d    = mode_q;
        mask_d    = mask_q;
        if (reg_we_i) begin
            case (reg_addr_i)
                ADDR_PENDING: pend_clr  = wdata;
                ADDR_MODE: begin
                    mode_d   = wdata;
                    mode_chg = wdata ^ mode_q;
                end
                ADDR_MASK:    mask_d    = wdata;
                ADDR_FORCE:   force_set = wdata;
                default: ;
            endcase
        end
    end

    // Per-source pending update; any set source beats a same-cycle clear.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (mode_chg[i]) begin
                // A mode flip drops the old state; only a fresh set survives.
                pending_d[i] = edge_det[i] | force_set[i];
            end else if (mode_q[i]) begin
                pending_d[i] = (pending_q[i] & ~pend_clr[i]) | edge_det[i] | force_set[i];
            end else begin
                pending_d[i] = s2_q[i] | force_set[i];
            end
        end
    end

    // Read mux and the zero-extended masked request vector.
    always_comb begin
        rdata_d = '0;
        case (reg_addr_i)
            ADDR_PENDING: rdata_d[N_SRC-1:0] = pending_q;
            ADDR_MODE:    rdata_d[N_SRC-1:0] = mode_q;
            ADDR_MASK:    rdata_d[N_SRC-1:0] = mask_q;
            ADDR_RAW:     rdata_d[N_SRC-1:0] = s2_q;
            default: ;
        endcase
        irq_out_d = '0;
        irq_out_d[N_SRC-1:0] = pending_q & mask_q;
    end

    // Synchronizer chain, history flop, and all register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q              <= '0;
            s2_q              <= '0;
            s3_q              <= '0;
            pending_q         <= '0;
            mode_q            <= '0;
            mask_q            <= '0;
            reg_data_o        <= '0;
            devices_interrupt <= '0;
        end else begin
            s1_q              <= irq_i;
            s2_q              <= s1_q;
            s3_q              <= s2_q;
            pending_q         <= pending_d;
            mode_q            <= mode_d;
            mask_q            <= mask_d;
            reg_data_o        <= rdata_d;
            devices_interrupt <= irq_out_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with hand-computed expectations.
module tb_irq_ctrl;

    localparam int unsigned N_SRC = 31;

    logic             clk;
    logic             rst_n;
    logic [N_SRC-1:0] irq_i;
    logic [2:0]       reg_addr_i;
    logic             reg_we_i;
    logic [31:0]      reg_data_i;
    logic [31:0]      reg_data_o;
    logic [31:0]      devices_interrupt;

    int n_vec;
    int n_err;

    irq_ctrl #(.N_SRC(N_SRC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .irq_i             (irq_i),
        .reg_addr_i        (reg_addr_i),
        .reg_we_i          (reg_we_i),
        .reg_data_i        (reg_data_i),
        .reg_data_o        (reg_data_o),
        .devices_interrupt (devices_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] addr, input logic [31:0] data);
        reg_addr_i = addr;
        reg_data_i = data;
        reg_we_i   = 1'b1;
        tick();
        reg_we_i   = 1'b0;
        reg_data_i = '0;
    endtask

    task automatic reg_rd(input logic [2:0] addr, output logic [31:0] data);
        reg_addr_i = addr;
        reg_we_i   = 1'b0;
        tick();
        data = reg_data_o;
    endtask

    logic [31:0] rd;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        irq_i      = '0;
        reg_addr_i = '0;
        reg_we_i   = 1'b0;
        reg_data_i = '0;
        tick();
        tick();
        check("reset_rdata", reg_data_o, 32'h0);
        check("reset_irq", devices_interrupt, 32'h0);
        rst_n = 1'b1;
        reg_rd(3'd0, rd); check("reset_pending", rd, 32'h0);
        reg_rd(3'd1, rd); check("reset_mode", rd, 32'h0);
        reg_rd(3'd2, rd); check("reset_mask", rd, 32'h0);

        // Edge mode on bit 3, 3-cycle pulse.
        reg_wr(3'd1, 32'h8);
        reg_wr(3'd2, 32'h8);
        irq_i[3] = 1'b1;
        tick();                     // E0: first sampling edge
        tick();                     // E1
        tick();                     // E2: pending set
        check("edge_latency_e2", devices_interrupt, 32'h0);
        irq_i[3] = 1'b0;
        tick();                     // E3
        check("edge_latency_e3", devices_interrupt, 32'h8);
        tick(); tick(); tick();
        check("edge_held", devices_interrupt, 32'h8);
        reg_rd(3'd0, rd); check("edge_pending", rd, 32'h8);
        reg_wr(3'd0, 32'h8);
        check("edge_clr_w", devices_interrupt, 32'h8);
        tick();
        check("edge_clr_w1", devices_interrupt, 32'h0);

        // Level mode on bit 0.
        reg_wr(3'd1, 32'h0);
        reg_wr(3'd2, 32'h7fff_ffff);
        irq_i[0] = 1'b1;
        tick(); tick(); tick(); tick();
        check("level_set", devices_interrupt, 32'h1);
        reg_rd(3'd3, rd); check("level_raw", rd, 32'h1);
        reg_wr(3'd0, 32'h1);
        tick(); tick();
        check("level_clr_ignored", devices_interrupt, 32'h1);
        irq_i[0] = 1'b0;
        tick(); tick(); tick();
        check("level_drop_e2", devices_interrupt, 32'h1);
        tick();
        check("level_drop_e3", devices_interrupt, 32'h0);

        // Edge on bit 5 collides with a PENDING clear of the same bit.
        reg_wr(3'd1, 32'h20);
        irq_i[5] = 1'b1;
        tick();                     // E0
        tick();                     // E1: edge visible to next edge
        reg_wr(3'd0, 32'h20);       // E2: set and clear together
        reg_rd(3'd0, rd); check("collision_set_wins", rd, 32'h20);
        reg_wr(3'd0, 32'h20);
        reg_rd(3'd0, rd); check("collision_clear", rd, 32'h0);
        irq_i[5] = 1'b0;

        // Mask gating on bit 7.
        reg_wr(3'd1, 32'ha0);
        reg_wr(3'd2, 32'h0);
        reg_wr(3'd4, 32'h80);
        tick();
        check("mask_hidden", devices_interrupt, 32'h0);
        reg_rd(3'd0, rd); check("mask_pending", rd, 32'h80);
        reg_rd(3'd4, rd); check("force_reads_0", rd, 32'h0);
        reg_wr(3'd2, 32'h80);
        check("mask_w", devices_interrupt, 32'h0);
        tick();
        check("mask_w1", devices_interrupt, 32'h80);

        // FORCE on bit 30 and on unimplemented bit 31.
        reg_wr(3'd1, 32'h4000_00a0);
        reg_wr(3'd2, 32'hffff_ffff);
        reg_rd(3'd2, rd); check("mask_bit31_ro", rd, 32'h7fff_ffff);
        reg_wr(3'd0, 32'h80);
        reg_wr(3'd4, 32'h4000_0000);
        tick();
        check("force_b30", devices_interrupt, 32'h4000_0000);
        reg_wr(3'd4, 32'h8000_0000);
        tick();
        check("force_b31", devices_interrupt, 32'h4000_0000);
        reg_rd(3'd0, rd); check("force_pending", rd, 32'h4000_0000);
        reg_wr(3'd5, 32'hffff_ffff);
        reg_rd(3'd5, rd); check("addr5_reads_0", rd, 32'h0);

        // Reset with bits pending; a write during reset must be dropped.
        reg_wr(3'd4, 32'h80);
        rst_n      = 1'b0;
        reg_addr_i = 3'd2;
        reg_data_i = 32'hff;
        reg_we_i   = 1'b1;
        tick();
        reg_we_i   = 1'b0;
        rst_n      = 1'b1;
        check("rst_irq", devices_interrupt, 32'h0);
        check("rst_rdata", reg_data_o, 32'h0);
        reg_rd(3'd0, rd); check("rst_pending", rd, 32'h0);
        reg_rd(3'd1, rd); check("rst_mode", rd, 32'h0);
        reg_rd(3'd2, rd); check("rst_mask", rd, 32'h0);
        reg_rd(3'd3, rd); check("rst_raw", rd, 32'h0);
        check("rst_irq_after", devices_interrupt, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
